// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and operand-signedness helpers
// for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic logic is_signed_lhs(
    input logic [2:0] f3
  );
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV)  || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_rhs(
    input logic [2:0] f3
  );
    return (f3 == F3_MULH) || (f3 == F3_DIV) ||
           (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done request bundle between the controller
// (master) and the multiply/divide unit (slave).
interface muldiv_if #(
  parameter int XLEN = 32
);
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      f3;
  logic [XLEN-1:0] lhs;
  logic [XLEN-1:0] rhs;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;

  modport master (
    output start, f3, lhs, rhs,
    input  busy, done, res
  );

  modport slave (
    input  start, f3, lhs, rhs,
    output busy, done, res
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, either a shift-add multiply step
// or a restoring trial-subtract divide step on a 2*XLEN accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_n
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rsh;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
           (acc[0] ? {1'b0, opnd} : '0);
    // shifted partial remainder needs one extra bit
    rsh  = acc[2*XLEN-1:XLEN-1];
    diff = rsh[XLEN-1:0] - opnd;
    ge   = rsh >= {1'b0, opnd};
    if (div) begin
      acc_n = {ge ? diff : rsh[XLEN-1:0],
               acc[XLEN-2:0], ge};
    end else begin
      acc_n = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide with start/busy/done.
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_n;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   res;
  logic              lneg;
  logic              rneg;
  logic              spc;

  logic              sl, sr, ln, rn;
  logic              isdiv, by0, ovf;
  logic              special, fast, accept;
  logic [XLEN-1:0]   lmag, rmag, sval;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sl      = is_signed_lhs(bus.f3);
    sr      = is_signed_rhs(bus.f3);
    ln      = sl & bus.lhs[XLEN-1];
    rn      = sr & bus.rhs[XLEN-1];
    lmag    = ln ? -bus.lhs : bus.lhs;
    rmag    = rn ? -bus.rhs : bus.rhs;
    isdiv   = bus.f3[2];
    by0     = bus.rhs == '0;
    ovf     = sl && (bus.lhs == MIN) &&
              (bus.rhs == '1);
    special = isdiv & (by0 | ovf);
    accept  = bus.start &
              ((state == IDLE) || (state == DONE));
    sval = '0;
    unique case (1'b1)
      by0 & ~bus.f3[1]:  sval = '1;
      by0 & bus.f3[1]:   sval = bus.lhs;
      ~by0 & ~bus.f3[1]: sval = bus.lhs;
      default:           sval = '0;
    endcase
`ifdef MULDIV_FAST_MUL_EN
    fast = ~isdiv;
    prod = {{XLEN{1'b0}}, lmag} *
           {{XLEN{1'b0}}, rmag};
`else
    fast = 1'b0;
    prod = '0;
`endif
  end

  always_comb begin
    state_n  = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        bus.done = state == DONE;
        if (accept) begin
          state_n = (special | fast) ? FIX : CALC;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        bus.busy = 1'b1;
        if (cnt == '0) state_n = FIX;
      end
      FIX: begin
        bus.busy = 1'b1;
        state_n  = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .div   (op[2]),
    .acc   (acc),
    .opnd  (opnd),
    .acc_n (acc_step)
  );

  logic              pneg;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   qs, rs, fixed;

  always_comb begin
    pneg   = lneg ^ rneg;
    prod_s = pneg ? -acc : acc;
    qs     = pneg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rs     = lneg ? -acc[2*XLEN-1:XLEN]
                  : acc[2*XLEN-1:XLEN];
    fixed  = '0;
    unique case (1'b1)
      spc:
        fixed = acc[XLEN-1:0];
      ~spc & ~op[2] & (op[1:0] == 2'b00):
        fixed = prod_s[XLEN-1:0];
      ~spc & ~op[2] & (op[1:0] != 2'b00):
        fixed = prod_s[2*XLEN-1:XLEN];
      ~spc & op[2] & ~op[1]:
        fixed = qs;
      ~spc & op[2] & op[1]:
        fixed = rs;
      default:
        fixed = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      acc   <= '0;
      opnd  <= '0;
      lneg  <= 1'b0;
      rneg  <= 1'b0;
      spc   <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            op   <= bus.f3;
            lneg <= ln;
            rneg <= rn;
            spc  <= special;
            cnt  <= CNT_W'(XLEN - 1);
            // divisor or multiplicand stays fixed
            opnd <= isdiv ? rmag : lmag;
            if (special) begin
              acc <= {{XLEN{1'b0}}, sval};
            end else if (fast) begin
              acc <= prod;
            end else begin
              acc <= {{XLEN{1'b0}},
                      isdiv ? lmag : rmag};
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
        end
        FIX: res <= fixed;
        default: ;
      endcase
    end
  end

  assign bus.res = res;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed vectors;
// MULDIV_FAST_MUL_EN shortens the expected multiply latency.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(
    .XLEN (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 expected 0");
      end else begin
        e = q.pop_front();
        chk({e.nm, "_res"}, bus.res, e.res);
        chk({e.nm, "_lat"}, 32'(cyc - e.t0),
            32'(e.lat));
      end
    end
  end

  task automatic issue(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] r,
    input int          lat,
    input string       nm
  );
    @(negedge clk);
    bus.start = 1'b1;
    bus.f3    = op;
    bus.lhs   = a;
    bus.rhs   = b;
    q.push_back('{res: r, lat: lat,
                  t0: cyc + 1, nm: nm});
    @(negedge clk);
    bus.start = 1'b0;
    bus.f3    = 3'($urandom);
    bus.lhs   = $urandom;
    bus.rhs   = $urandom;
  endtask

  task automatic wait_empty(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: %0d pending expected 0",
               nm, q.size());
      q.delete();
    end
  endtask

  task automatic run(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] r,
    input int          lat,
    input string       nm
  );
    issue(op, a, b, r, lat, nm);
    wait_empty(nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin : stim
    bit seen;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.f3    = '0;
    bus.lhs   = '0;
    bus.rhs   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_res", bus.res, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD,
          32'hFFFF_FFEB, ML, "mul");
    chk("busy_e0", {31'b0, bus.busy}, 32'd1);
    for (int k = 1; k < ML; k++) begin
      @(negedge clk);
      chk("busy_mid", {31'b0, bus.busy}, 32'd1);
    end
    @(negedge clk);
    chk("busy_end", {31'b0, bus.busy}, 32'd0);
    wait_empty("mul");

    run(F3_MULH, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, ML, "mulh");
    run(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, ML, "mulhu");
    run(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, ML, "mulhsu");
    run(F3_DIV, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFD, 33, "div");
    run(F3_REM, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 33, "rem");
    run(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu");
    run(F3_REMU, 32'd100, 32'd7, 32'd2, 33, "remu");
    run(F3_DIVU, 32'd5, 32'd0,
        32'hFFFF_FFFF, 1, "divu0");
    run(F3_REM, 32'd5, 32'd0, 32'd5, 1, "rem0");
    run(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1, "divovf");
    run(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 1, "removf");
    run(F3_DIV, 32'd9, 32'd0,
        32'hFFFF_FFFF, 1, "div0");

    issue(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "ign");
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.f3    = F3_MUL;
    bus.lhs   = 32'd3;
    bus.rhs   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_empty("ign");

    issue(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "b2b_a");
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b2b_wait: done=0 expected 1");
    end
    bus.start = 1'b1;
    bus.f3    = F3_REMU;
    bus.lhs   = 32'd100;
    bus.rhs   = 32'd7;
    q.push_back('{res: 32'd2, lat: 33,
                  t0: cyc + 1, nm: "b2b_b"});
    @(negedge clk);
    bus.start = 1'b0;
    wait_empty("b2b");

    issue(F3_DIVU, 32'd200, 32'd7, 32'd28, 33, "rst_op");
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_res", bus.res, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    run(F3_MUL, 32'd6, 32'd7, 32'd42, ML, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
